// File: rtl/mem_bus_pkg.sv
// Shared constants for the mem_bus slice: UART register addresses, FIFO depth,
// UART TX state encodings and the status word layout.
package mem_bus_pkg;

  localparam logic [15:0] ADDR_UART_DATA   = 16'hFF00;
  localparam logic [15:0] ADDR_UART_STATUS = 16'hFF04;
  localparam int unsigned FIFO_DEPTH       = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  typedef struct packed {
    logic overflow;
    logic busy;
    logic empty;
    logic full;
  } uart_status_t;

endpackage

// File: rtl/mem_bus_if.sv
// CPU-side memory bus: single-cycle read/write requests and registered read response.
interface mem_bus_if;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (
    output rd_en, wr_en, addr, wr_data, wr_mask,
    input  rd_data, rd_valid
  );

  modport slave (
    input  rd_en, wr_en, addr, wr_data, wr_mask,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/uart_tx.sv
// 8-entry byte FIFO feeding an 8N1 UART transmitter; CLK_DIV clk cycles per bit.
module uart_tx
  import mem_bus_pkg::*;
#(
  parameter int unsigned CLK_DIV = 104
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [7:0]   push_data,
  input  logic         stat_rd,
  output uart_status_t status,
  output logic         tx
);

  localparam int unsigned    CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [2:0]    wr_ptr;
  logic [2:0]    rd_ptr;
  logic [3:0]    count;
  logic          overflow;
  uart_state_t   state;
  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic full;
  logic empty;
  logic bit_end;
  logic pop;
  logic push_ok;

  assign full    = (count == 4'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign bit_end = (div_cnt == DIV_LAST);
  // Pop either from idle or straight out of the stop bit, so back-to-back frames have no gap.
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign push_ok = push && !full;
  assign status  = {overflow, (state != IDLE), empty, full};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 3'd1;
      if (pop)     rd_ptr <= rd_ptr + 3'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: ;
      endcase
      if (push && full)  overflow <= 1'b1;
      else if (stat_rd)  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      div_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      div_cnt <= ((state == IDLE) || bit_end) ? '0 : div_cnt + CW'(1);
      case (state)
        IDLE: begin
          if (pop) begin
            state <= START;
            shreg <= fifo_mem[rd_ptr];
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              state <= START;
              shreg <= fifo_mem[rd_ptr];
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus.sv
// CPU memory bus: byte-masked word RAM plus optional UART TX registers at 0xFF00/0xFF04.
// Define MEM_BUS_UART_EN to build the UART; otherwise those addresses are unmapped.
module mem_bus
  import mem_bus_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 4096,
  parameter int unsigned CLK_DIV   = 104
) (
  input  logic           clk,
  input  logic           rst,
  mem_bus_if.slave       bus,
  output logic           uart_tx
);

  localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [16:0] RAM_BYTES = 17'(4 * RAM_WORDS);

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] widx;
  logic          ram_hit;
  logic          rd_req;
  logic [31:0]   rd_mux;

  assign widx    = bus.addr[AW+1:2];
  assign ram_hit = ({1'b0, bus.addr} < RAM_BYTES);
  // A simultaneous write wins; the read is dropped entirely.
  assign rd_req  = bus.rd_en && !bus.wr_en;

  always_ff @(posedge clk) begin
    if (bus.wr_en && ram_hit) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (bus.wr_mask[3-k]) ram[widx][8*k +: 8] <= bus.wr_data[8*k +: 8];
      end
    end
  end

`ifdef MEM_BUS_UART_EN
  uart_status_t status;
  logic         is_data;
  logic         is_status;

  assign is_data   = (bus.addr[15:2] == ADDR_UART_DATA[15:2]);
  assign is_status = (bus.addr[15:2] == ADDR_UART_STATUS[15:2]);

  uart_tx #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.wr_en && is_data && bus.wr_mask[3]),
    .push_data (bus.wr_data[7:0]),
    .stat_rd   (rd_req && is_status),
    .status    (status),
    .tx        (uart_tx)
  );

  always_comb begin
    rd_mux = '0;
    if (ram_hit)        rd_mux = ram[widx];
    else if (is_status) rd_mux = {28'b0, status};
  end
`else
  assign uart_tx = 1'b1;

  always_comb begin
    rd_mux = '0;
    if (ram_hit) rd_mux = ram[widx];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.rd_valid <= rd_req;
      if (rd_req) bus.rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mem_bus.sv
// Scoreboard bench for mem_bus: reads push expected words, the negedge monitor pops and compares.
module tb_mem_bus;
  import mem_bus_pkg::*;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst;
  logic uart_tx;

  mem_bus_if bus ();

  mem_bus #(.RAM_WORDS(4096), .CLK_DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  rx_q  [$];
  logic [31:0] mdl   [4096];
  logic        pend  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read response monitor: rd_valid must follow the previous cycle's effective read.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (rst) begin
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      pend <= 1'b0;
    end else begin
      chk("rd_valid", 32'(bus.rd_valid), 32'(pend));
      if (pend && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (bus.rd_valid) chk("rd_data", bus.rd_data, e);
      end
      pend <= bus.rd_en && !bus.wr_en;
    end
  end

  // Serial receiver sampling mid-bit.
  initial begin : rx
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        repeat (DIV/2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge clk);
          b[k] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
    end
  endtask

  task automatic mdl_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
    if (a < 16'h4000)
      for (int k = 0; k < 4; k++)
        if (m[3-k]) mdl[a[13:2]][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b1;
    bus.addr = a; bus.wr_data = d; bus.wr_mask = m;
    mdl_write(a, d, m);
  endtask

  task automatic wr_rd(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
    @(posedge clk); #1;
    bus.rd_en = 1'b1; bus.wr_en = 1'b1;
    bus.addr = a; bus.wr_data = d; bus.wr_mask = m;
    mdl_write(a, d, m);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.addr = a;
    exp_q.push_back(exp);
  endtask

  task automatic rd_ram(input logic [15:0] a);
    rd(a, mdl[a[13:2]]);
  endtask

  task automatic wait_tx_low(input string tag);
    int unsigned c;
    c = 0;
    while (uart_tx !== 1'b0 && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(uart_tx), 32'd0);
  endtask

  initial begin : main
    logic [15:0] a;
    logic [7:0]  byte_v;
    logic        e;
    int unsigned lows;

    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    bus.addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
    for (int i = 0; i < 4096; i++) mdl[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_rd_data", bus.rd_data, 32'd0);
    chk("reset_uart_tx", 32'(uart_tx), 32'd1);
    rst = 1'b0;

    // Full write then read, then single-lane update of byte 1.
    wr(16'h0100, 32'h11223344, 4'b1111);
    rd(16'h0100, 32'h11223344);
    wr(16'h0101, 32'h0000AA00, 4'b0100);
    rd(16'h0101, 32'h1122AA44);
    wr(16'h0200, 32'hAABBCCDD, 4'b1111);
    wr(16'h0200, 32'h01020304, 4'b1001);
    rd(16'h0203, 32'h01BBCC04);

    // RAM top boundary and unmapped space; 0x4000 must not alias word 0.
    wr(16'h0000, 32'hCAFEF00D, 4'b1111);
    wr(16'h3FFC, 32'h12345678, 4'b1111);
    wr(16'h4000, 32'hDEADBEEF, 4'b1111);
    rd(16'h0000, 32'hCAFEF00D);
    rd(16'h3FFF, 32'h12345678);
    rd(16'h4000, 32'h0);
    rd(16'h8000, 32'h0);
    rd(16'hFFFC, 32'h0);

    // Write and read together: write only, no response.
    wr_rd(16'h0300, 32'h0BADF00D, 4'b1111);
    rd(16'h0300, 32'h0BADF00D);
    idle_cyc(2);

    // Random masked traffic over 16 words.
    for (int i = 0; i < 16; i++) wr(16'h0500 + 16'(4*i), 32'(i) * 32'h01010101, 4'b1111);
    for (int i = 0; i < 40; i++) begin
      a = 16'h0500 + 16'(4 * $urandom_range(0, 15)) + 16'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) wr(a, $urandom, 4'($urandom_range(0, 15)));
      else rd_ram(a);
    end
    idle_cyc(2);

    // RAM survives reset; a single read gives a single-cycle rd_valid.
    wr(16'h0080, 32'h80808080, 4'b1111);
    rd(16'h0080, 32'h80808080);
    idle_cyc(2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_rd_data_clr", bus.rd_data, 32'd0);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    rd(16'h0080, 32'h80808080);
    idle_cyc(3);

`ifdef MEM_BUS_UART_EN
    rd(ADDR_UART_STATUS, 32'h2);
    rd(ADDR_UART_DATA, 32'h0);
    idle_cyc(1);

    // Single 0x55 frame checked cycle by cycle.
    wr(ADDR_UART_DATA, 32'h00000055, 4'b1000);
    idle_cyc(1);
    wait_tx_low("tx_start_55");
    byte_v = 8'h55;
    for (int c = 0; c < 44; c++) begin
      if (c < 4)       e = 1'b0;
      else if (c < 36) e = byte_v[(c-4)/4];
      else             e = 1'b1;
      chk("tx_frame_55", 32'(uart_tx), 32'(e));
      @(negedge clk);
    end
    chk("rx_count_55", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("rx_byte_55", 32'(rx_q.pop_front()), 32'h55);

    // Ten pushes back to back: one popped, eight queued, last one overflows.
    for (int i = 0; i < 10; i++) wr(ADDR_UART_DATA, 32'h10 + 32'(i), 4'b1000);
    rd(ADDR_UART_STATUS, 32'hD);
    rd(ADDR_UART_STATUS, 32'h5);
    idle_cyc(1);
    for (int c = 0; c < 500 && rx_q.size() < 9; c++) @(negedge clk);
    repeat (80) @(negedge clk);
    chk("rx_count_burst", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9 && rx_q.size() > 0; i++)
      chk("rx_byte_burst", 32'(rx_q.pop_front()), 32'h10 + 32'(i));
    rd(ADDR_UART_STATUS, 32'h2);
    idle_cyc(1);

    // Reset in the middle of data bit 0 (a low bit) aborts the frame.
    wr(ADDR_UART_DATA, 32'h0000005A, 4'b1000);
    idle_cyc(1);
    wait_tx_low("tx_start_5a");
    repeat (6) @(negedge clk);
    chk("tx_bit0_5a", 32'(uart_tx), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_abort_tx", 32'(uart_tx), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    rd(ADDR_UART_STATUS, 32'h2);
    idle_cyc(1);
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("tx_quiet_after_rst", 32'(lows), 32'd0);
    rx_q.delete();
`else
    // Without the UART the register addresses are plain unmapped space.
    wr(ADDR_UART_DATA, 32'h00000055, 4'b1000);
    wr(ADDR_UART_STATUS, 32'hFFFFFFFF, 4'b1111);
    rd(ADDR_UART_DATA, 32'h0);
    rd(ADDR_UART_STATUS, 32'h0);
    idle_cyc(1);
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("tx_const_high", 32'(lows), 32'd0);
`endif

    idle_cyc(3);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
